// File: rtl/m_mem_access.sv
// m_mem_access: M-stage load/store unit with lane select/extend and req/ack bus handshake, optional MISALIGN_CHECK_EN
module m_mem_access #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;
  logic        valid, is_store, misalign;
  logic [3:0]  be_n;
  logic [31:0] wd_n, shifted, ext;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  always_comb begin
    valid    = mem_op >= 4'd1 && mem_op <= 4'd8;
    is_store = mem_op >= 4'd6;
    be_n     = mem_op == 4'd8 ? 4'b0001 << addr[1:0] : mem_op == 4'd7 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_n     = mem_op == 4'd8 ? {4{wdata[7:0]}} : mem_op == 4'd7 ? {2{wdata[15:0]}} : wdata;
`ifdef MISALIGN_CHECK_EN
    misalign = ((mem_op == 4'd1 || mem_op == 4'd6) && addr[1:0] != 2'b00) ||
               ((mem_op == 4'd2 || mem_op == 4'd3 || mem_op == 4'd7) && addr[0]);
`else
    misalign = 1'b0;
`endif
    shifted  = bus_rdata >> {off_q, 3'b000};
    byte_l   = shifted[7:0];
    half_l   = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ext      = op_q == 4'd1 ? bus_rdata :
               op_q == 4'd2 ? {{16{half_l[15]}}, half_l} :
               op_q == 4'd3 ? {16'h0, half_l} :
               op_q == 4'd4 ? {{24{byte_l[7]}}, byte_l} : {24'h0, byte_l};
    stall    = state == BUSY || (state == IDLE && req && valid);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      off_q     <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req && valid) begin
            op_q  <= mem_op;
            off_q <= addr[1:0];
            cnt   <= '0;
            if (misalign) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state     <= BUSY;
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_be    <= be_n;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= wd_n;
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            if (op_q < 4'd6) rdata <= ext;
          end else if (cnt == 8'(MAX_WAIT - 1)) begin
            state   <= DONE;
            bus_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            rdata   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_m_mem_access.sv
// tb_m_mem_access: randomized scoreboard bench for m_mem_access
module tb_m_mem_access;
  localparam int MAXW = 15;
  logic        clk = 1'b0, reset = 1'b1, req = 1'b0, bus_ack = 1'b0;
  logic [3:0]  mem_op = '0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic        stall, done, err, bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] rdata, bus_addr, bus_wdata;
  int nvec = 0, nerr = 0;
  typedef struct {logic [31:0] a; logic [3:0] be; logic we; logic [31:0] wd; int len;} bus_t;
  typedef struct {logic err; logic chk_rd; logic [31:0] rd;} rsp_t;
  bus_t bq[$];
  rsp_t rq[$];
  m_mem_access #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .req(req), .mem_op(mem_op), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_load(logic [3:0] op, logic [1:0] off, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * off));
    h = 16'(w >> (16 * off[1]));
    case (op)
      4'd1: return w;
      4'd2: return 32'($signed(h));
      4'd3: return 32'(h);
      4'd4: return 32'($signed(b));
      default: return 32'(b);
    endcase
  endfunction
  // monitor: bus-side and response-side scoreboard checks
  logic prev_req = 1'b0, hold_ok = 1'b1;
  logic [31:0] hold_rd = '0;
  int blen = 0;
  bus_t cur;
  rsp_t r;
  always @(negedge clk) begin
    if (bus_req && !prev_req) begin
      blen = 0;
      if (bq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL bus_unexpected: got bus_req=1 expected 0");
        cur = '{bus_addr, bus_be, bus_we, bus_wdata, 0};
      end else cur = bq.pop_front();
    end
    if (bus_req) begin
      blen++;
      chk("bus_addr", bus_addr, cur.a);
      chk("bus_be", 32'(bus_be), 32'(cur.be));
      chk("bus_we", 32'(bus_we), 32'(cur.we));
      if (cur.we) chk("bus_wdata", bus_wdata, cur.wd);
      chk("stall_busy", 32'(stall), 32'd1);
    end
    if (!bus_req && prev_req) chk("bus_len", blen, cur.len);
    prev_req = bus_req;
    if (done) begin
      chk("stall_done", 32'(stall), 32'd0);
      if (rq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL done_unexpected: got done=1 expected 0");
      end else begin
        r = rq.pop_front();
        chk("err", 32'(err), 32'(r.err));
        if (r.chk_rd) chk("rdata", rdata, r.rd);
        hold_ok = r.chk_rd;
        hold_rd = r.rd;
      end
    end else if (hold_ok) chk("rdata_hold", rdata, hold_rd);
    if (reset) begin
      hold_ok = 1'b1;
      hold_rd = '0;
    end
  end
  task automatic access(logic [3:0] op, logic [31:0] a, logic [31:0] wd, logic [31:0] word, int lat);
    logic [1:0] off;
    logic valid, store, mis;
    logic [3:0] be;
    logic [31:0] sd;
    int n;
    off = a[1:0];
    valid = op >= 1 && op <= 8;
    store = op >= 6;
    mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis = ((op == 1 || op == 6) && off != 0) || ((op == 2 || op == 3 || op == 7) && off[0]);
`endif
    be = op == 8 ? 4'(1 << off) : op == 7 ? (off[1] ? 4'hC : 4'h3) : 4'hF;
    sd = op == 8 ? 32'(wd[7:0]) * 32'h0101_0101 : op == 7 ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
    if (valid && !mis) bq.push_back('{a & ~32'd3, store ? be : 4'hF, store, sd, lat < 0 ? MAXW : lat + 1});
    if (valid) rq.push_back('{lat < 0 || mis, !store || lat < 0 || mis,
                              (lat < 0 || mis) ? 32'd0 : ref_load(op, off, word)});
    mem_op = op; addr = a; wdata = wd; req = 1'b1;
    #1 chk("stall_accept", 32'(stall), 32'(valid));
    @(negedge clk);
    req = 1'b0; mem_op = 4'($urandom); addr = $urandom;
    if (!valid) return;
    if (mis) begin
      chk("mis_done", 32'(done), 32'd1);
      @(negedge clk);
      return;
    end
    if (lat >= 0) begin
      repeat (lat) @(negedge clk);
      bus_ack = 1'b1; bus_rdata = word;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
    end
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {stall, done, err, bus_req, bus_we, bus_be}, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_addr", bus_addr, '0);
    chk("rst_wdata", bus_wdata, '0);
    reset = 1'b0;
    @(negedge clk);
    access(4'd4, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2);
    access(4'd3, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 1);
    access(4'd2, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0);
    access(4'd8, 32'h0000_0011, 32'h1234_56AB, 32'h0, 3);
    access(4'd7, 32'h0000_0012, 32'h1234_56AB, 32'h0, 2);
    access(4'd1, 32'h0000_0040, 32'h0, 32'h0, -1);
    access(4'd1, 32'h0000_0002, 32'h0, 32'hCAFE_F00D, 1);
    access(4'd0, 32'h0000_0000, 32'h0, 32'h0, 0);
    access(4'd12, 32'h0000_0000, 32'h0, 32'h0, 0);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    // reset during the second BUSY cycle of a store; the later ack must be ignored
    bq.push_back('{32'h0000_0100, 4'hF, 1'b1, 32'hDEAD_BEEF, 2});
    mem_op = 4'd6; addr = 32'h0000_0100; wdata = 32'hDEAD_BEEF; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busreq", 32'(bus_req), 32'd0);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    repeat (3) begin
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 250; i++)
      access(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
             ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5)));
    repeat (5) @(negedge clk);
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/m_mem_access.md
Name: m_mem_access

Overview:
- Memory-stage load/store access unit, the data-path counterpart of the decode-stage immediate extender.
- Store path: narrows register data to byte/halfword lanes with byte enables.
- Load path: selects the addressed lane from the bus word and sign- or zero-extends it to 32 bits.
- Sits between the M-stage pipeline register and a word-wide data bus with a req/ack handshake; stalls the pipeline while a transfer is outstanding.

Parameters:
- MAX_WAIT, 15: maximum cycles in BUSY without bus_ack before the access aborts with err (range 1..255).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req  input  1  pipeline requests an access this cycle (sampled only in IDLE)
- mem_op  input  4  0 NOP, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 treated as NOP
- addr  input  32  byte address
- wdata  input  32  store data (low bits used for SH/SB)
- stall  output  1  freeze upstream stages
- done  output  1  one-cycle pulse: access complete
- rdata  output  32  extended load result, valid while done=1, held until next done
- err  output  1  valid with done: timeout, or misalignment if enabled
- bus_req  output  1  bus transfer request
- bus_we  output  1  1 = write
- bus_be  output  4  byte enables, bit k = bits [8k+7:8k]
- bus_addr  output  32  word address {addr[31:2],2'b00}
- bus_wdata  output  32  lane-replicated store data
- bus_rdata  input  32  read word
- bus_ack  input  1  bus completes transfer this cycle

Behaviour:
- Reset (sync, high): state IDLE; stall=0, done=0, err=0, rdata=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0; wait counter=0.
- States IDLE, BUSY, DONE.
- IDLE, req=1, valid op (1-8): latch op and addr[1:0]; register bus_addr, bus_we, bus_be, bus_wdata; set bus_req=1; go BUSY. stall=1 combinationally in this cycle.
- IDLE, req=0 or NOP: stay IDLE, stall=0, no bus activity.
- BUSY: stall=1. All bus outputs held stable until ack. Counter increments each cycle.
- BUSY, bus_ack=1: bus_req=0 next edge; go DONE. For loads, rdata registers the extended lane; err=0.
- BUSY, counter reaches MAX_WAIT with no ack: bus_req=0; go DONE with err=1, rdata=0. An ack arriving in the same cycle the timeout fires wins (normal completion).
- DONE: done=1 and stall=0 for exactly one cycle, then IDLE. req is not sampled in DONE; it is accepted the following cycle.
- A bus_ack seen in IDLE or DONE is ignored.
- Store enables and data:
  - SW: be=1111, data=wdata.
  - SH: be=0011 if addr[1]=0, else 1100; data={wdata[15:0],wdata[15:0]}.
  - SB: be=0001<<addr[1:0]; data={4{wdata[7:0]}}.
- Load lane selection: byte k = bus_rdata[8k+7:8k], k=addr[1:0]; halfword = bus_rdata[31:16] if addr[1]=1, else [15:0].
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Loads drive be=1111 and bus_we=0.
- Reset mid-access: reset dominates. Bus signals drop at that edge, state returns to IDLE, and a later ack is ignored.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- When defined: in IDLE, these are misaligned:
  - LW/SW with addr[1:0]!=0
  - LH/LHU/SH with addr[0]=1
  A misaligned access issues no bus transaction (bus_req stays 0) and goes directly to DONE with err=1, rdata=0 (stall=1 for the accept cycle only).
- When undefined: addr[0] is ignored for halfwords and addr[1:0] for words; the access proceeds normally.

Test Plan:
- Reset, then LB at addr 0x0000_1003, bus_rdata=0x80FF_1234, ack after 2 cycles -> bus_addr=0x0000_1000, bus_be=1111, done pulse, rdata=0xFFFF_FF80, err=0.
- LHU at 0x0000_2002, rdata word 0x8001_7FFF -> rdata=0x0000_8001; repeat with LH -> rdata=0xFFFF_8001.
- SB at 0x0000_0011, wdata=0x1234_56AB -> bus_we=1, bus_be=0010, bus_wdata=0xABAB_ABAB, held stable until ack; SH at 0x12 -> be=1100, data=0x56AB_56AB.
- LW with bus_ack never asserted, MAX_WAIT=15 -> bus_req drops after 15 BUSY cycles, done=1, err=1, rdata=0; stall high throughout BUSY.
- Reset asserted on the second BUSY cycle of SW, then ack pulsed one cycle later -> bus_req=0 after the reset edge, no done pulse, state IDLE.
- With MISALIGN_CHECK_EN, LW at 0x0000_0002 -> bus_req never rises, done=1 with err=1 on the next cycle; without the macro -> normal bus read at 0x0000_0000.
